multiword_add_sequencer: RTL and testbench

- Streaming front/back-end for the 16-bit carry-lookahead adder.
- Accepts multi-word operands one WIDTH-bit word per beat, least-significant word first.
- Drives the adder's a/b/cin, then registers sum/cout into an output stage with valid/ready flow control.
- Chains the carry across words and supports add and subtract.
- Produces final carry-out and signed overflow on the last word.

---
 rtl/multiword_add_sequencer.sv | 177 +++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - streaming multi-word add/subtract sequencer around an external adder
//
// Purpose:
//   Accepts multi-word operands one WIDTH-bit word per beat, least-significant
//   word first. The block steers each word into an external combinational
//   adder and registers the adder result into a valid/ready output stage.
//   The carry is chained between words. On the final word it also reports
//   the carry-out and the signed overflow.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   input word handshake
//   in_a, in_b            operand words
//   in_cin                initial carry (first word of an add only)
//   in_sub                1 = A-B (first word only)
//   in_last               marks the most-significant word
//   add_a/add_b/add_cin   drive to the external adder
//   add_sum/add_cout      result from the external adder
//   out_valid / out_ready result word handshake
//   out_sum, out_idx      result word and its index (0 = LS word)
//   out_last              final word of the operation
//   out_cout, out_ovf     carry-out / signed overflow (final word only)
//   out_err               length error: MAX_WORDS reached without in_last

module multiword_add_sequencer #(
    parameter int WIDTH     = 16,
    parameter int MAX_WORDS = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             in_last,

    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic             carry_q;
    logic             carry_d;
    logic             sub_q;
    logic             sub_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    logic             valid_d;
    logic [WIDTH-1:0] sum_d;
    logic [IDX_W-1:0] oidx_d;
    logic             last_d;
    logic             cout_d;
    logic             ovf_d;
    logic             err_d;

    logic             sub_eff;
    logic             accept;
    logic             at_max;
    logic             last_eff;
    logic             ovf_calc;

    // The subtract mode and carry source come from the live inputs on the
    // first word. Later words use the values captured when the operation started.
    assign sub_eff  = (state_q == IDLE) ? in_sub : sub_q;

    assign add_a    = in_a;
    assign add_b    = sub_eff ? ~in_b : in_b;
    // A subtract is A + ~B + 1, so the first word of a subtract forces cin.
    assign add_cin  = (state_q == IDLE) ? (in_sub | in_cin) : carry_q;

    // The output stage can take a new word if it is empty or being drained
    // this cycle. This gives full throughput with a single register stage.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign at_max   = (idx_q == IDX_MAX);
    assign last_eff = in_last || at_max;

    // Two's-complement overflow: the operands seen by the adder have the same
    // sign and the result sign differs from it.
    assign ovf_calc = (in_a[WIDTH-1] == add_b[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != in_a[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        valid_d = out_valid;
        sum_d   = out_sum;
        oidx_d  = out_idx;
        last_d  = out_last;
        cout_d  = out_cout;
        ovf_d   = out_ovf;
        err_d   = out_err;

        if (accept) begin
            valid_d = 1'b1;
            sum_d   = add_sum;
            oidx_d  = idx_q;
            carry_d = add_cout;
            last_d  = last_eff;
            err_d   = at_max && !in_last;
            if (state_q == IDLE) begin
                sub_d = in_sub;
            end
            if (last_eff) begin
                cout_d  = add_cout;
                ovf_d   = ovf_calc;
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
                state_d = ACTIVE;
                idx_d   = idx_q + IDX_ONE;
            end
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            carry_q   <= carry_d;
            sub_q     <= sub_d;
            idx_q     <= idx_d;
            out_valid <= valid_d;
            out_sum   <= sum_d;
            out_idx   <= oidx_d;
            out_last  <= last_d;
            out_cout  <= cout_d;
            out_ovf   <= ovf_d;
            out_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - self-checking bench for multiword_add_sequencer
module tb_multiword_add_sequencer;

    localparam int W  = 16;
    localparam int MW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic          in_sub = 1'b0;
    logic          in_last = 1'b0;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_cout;
    logic          out_ovf;
    logic          out_err;

    always #5 clk = ~clk;

    // External adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    multiword_add_sequencer #(.WIDTH(W), .MAX_WORDS(MW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sub(in_sub), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_idx(out_idx), .out_last(out_last), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_err(out_err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic         last;
    } in_word_t;

    typedef struct {
        logic [W-1:0]  sum;
        logic [IW-1:0] idx;
        logic          last;
        logic          cout;
        logic          ovf;
        logic          err;
    } exp_t;

    in_word_t inq[$];
    exp_t     expq[$];
    exp_t     e_cur;

    int       checks = 0;
    int       errors = 0;
    bit       sb_en = 1'b0;
    bit       hold_prev = 1'b0;
    logic [23:0] held = '0;

    function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    function automatic in_word_t mk(logic [W-1:0] a, logic [W-1:0] b,
                                    logic cin, logic sub, logic last);
        in_word_t w;
        w.a = a; w.b = b; w.cin = cin; w.sub = sub; w.last = last;
        return w;
    endfunction

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Reference model: split the word stream into operations, then compute
    // each operation as one wide integer add or subtract.
    task automatic model_ops();
        int s;
        int n;
        int L;
        logic [128:0] A;
        logic [128:0] B;
        logic [128:0] R;
        logic [128:0] mask;
        logic sa;
        logic sb;
        logic sr;
        exp_t e;
        s = 0;
        while (s < inq.size()) begin
            n = 1;
            while (!inq[s+n-1].last && n < MW && s + n < inq.size()) n++;
            L = n * W;
            A = '0;
            B = '0;
            for (int k = 0; k < n; k++) begin
                A[k*W +: W] = inq[s+k].a;
                B[k*W +: W] = inq[s+k].b;
            end
            mask = (129'd1 << L) - 129'd1;
            if (inq[s].sub) R = A + (~B & mask) + 129'd1;
            else            R = A + B + {128'd0, inq[s].cin};
            sa = A[L-1];
            sb = B[L-1];
            sr = R[L-1];
            for (int k = 0; k < n; k++) begin
                e.sum  = R[k*W +: W];
                e.idx  = IW'(k);
                e.last = (k == n - 1);
                e.cout = (k == n - 1) ? R[L] : 1'b0;
                e.ovf  = (k == n - 1) ? (inq[s].sub ? (sa != sb && sr != sa)
                                                    : (sa == sb && sr != sa)) : 1'b0;
                e.err  = (k == n - 1) && (n == MW) && !inq[s+n-1].last;
                expq.push_back(e);
            end
            s += n;
        end
    endtask

    task automatic present(input in_word_t w);
        in_valid = 1'b1;
        in_a     = w.a;
        in_b     = w.b;
        in_cin   = w.cin;
        in_sub   = w.sub;
        in_last  = w.last;
    endtask

    // Hold the word until it is accepted. Return the cycles taken.
    task automatic send(input in_word_t w, input bit rnd, output int cyc);
        bit acc;
        present(w);
        cyc = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            if (!acc && cyc >= 64) begin
                check("send_timeout", 32'd0, 32'd1);
                acc = 1'b1;
            end
        end
    endtask

    task automatic run_queue(input bit rnd);
        int c;
        model_ops();
        foreach (inq[i]) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            send(inq[i], rnd, c);
        end
        inq.delete();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && expq.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", expq.size(), 32'd0);
    endtask

    // Scoreboard and hold-stability monitor.
    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            if (hold_prev)
                check("hold_stable",
                      {out_sum, out_idx, out_last, out_cout, out_ovf, out_err, out_valid}, held);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e_cur = expq.pop_front();
                    check("sb_sum",  out_sum,  e_cur.sum);
                    check("sb_idx",  out_idx,  e_cur.idx);
                    check("sb_last", out_last, e_cur.last);
                    check("sb_cout", out_cout, e_cur.cout);
                    check("sb_ovf",  out_ovf,  e_cur.ovf);
                    check("sb_err",  out_err,  e_cur.err);
                end
            end
            hold_prev <= out_valid && !out_ready;
            held      <= {out_sum, out_idx, out_last, out_cout, out_ovf, out_err, out_valid};
        end else begin
            hold_prev <= 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int n;
        bit forced;
        logic [23:0] snap;
        in_word_t w[4];

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_sum",   out_sum,   32'd0);
        check("rst_out_idx",   out_idx,   32'd0);
        check("rst_flags",     {out_last, out_cout, out_ovf, out_err}, 32'd0);
        check("rst_in_ready",  in_ready,  32'd1);
        rst_n = 1'b1;
        sb_en = 1'b1;

        // Single-word add
        inq.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1));
        run_queue(1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_valid", out_valid, 32'd1);
        check("t1_sum",   out_sum,   32'h0000);
        check("t1_cout",  out_cout,  32'd1);
        check("t1_ovf",   out_ovf,   32'd0);
        check("t1_last",  out_last,  32'd1);
        check("t1_idx",   out_idx,   32'd0);
        @(posedge clk);
        #1;

        // Two-word add with the carry chained into the second beat
        inq.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0));
        inq.push_back(mk(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1));
        model_ops();
        send(inq[0], 1'b0, c);
        present(inq[1]);
        @(negedge clk);
        check("t2_w0_sum",   out_sum,  32'h0000);
        check("t2_w0_idx",   out_idx,  32'd0);
        check("t2_w0_last",  out_last, 32'd0);
        check("t2_w0_cout",  out_cout, 32'd0);
        check("t2_add_cin",  add_cin,  32'd1);
        check("t2_in_ready", in_ready, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inq.delete();
        @(negedge clk);
        check("t2_w1_sum",  out_sum,  32'h0002);
        check("t2_w1_idx",  out_idx,  32'd1);
        check("t2_w1_last", out_last, 32'd1);
        check("t2_w1_cout", out_cout, 32'd0);
        @(posedge clk);
        #1;

        // Subtracts
        inq.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1));
        run_queue(1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_sum",  out_sum,  32'hFFFE);
        check("t3_cout", out_cout, 32'd0);
        check("t3_ovf",  out_ovf,  32'd0);
        @(posedge clk);
        #1;
        inq.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1));
        run_queue(1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_sum",  out_sum,  32'h7FFF);
        check("t4_cout", out_cout, 32'd1);
        check("t4_ovf",  out_ovf,  32'd1);
        @(posedge clk);
        #1;
        // in_sub is dropped on the second word
        inq.push_back(mk(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0));
        inq.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1));
        run_queue(1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_sum",  out_sum,  32'hFFFF);
        check("t5_cout", out_cout, 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Backpressure
        for (int k = 0; k < 4; k++) begin
            w[k] = mk(rv(), rv(), 1'($urandom), 1'b0, (k == 3));
            inq.push_back(w[k]);
        end
        model_ops();
        inq.delete();
        out_ready = 1'b0;
        send(w[0], 1'b0, c);
        present(w[1]);
        @(negedge clk);
        snap = {out_sum, out_idx, out_last, out_cout, out_ovf, out_err, out_valid};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 32'd0);
            check("bp_stable", {out_sum, out_idx, out_last, out_cout, out_ovf, out_err, out_valid}, snap);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            send(w[k], 1'b0, c);
            check("bp_throughput", c, 32'd1);
        end
        drain();

        // Length error: eight words without in_last, then a fresh word
        for (int k = 0; k < 8; k++) inq.push_back(mk(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0));
        run_queue(1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("le_idx",  out_idx,  32'd7);
        check("le_last", out_last, 32'd1);
        check("le_err",  out_err,  32'd1);
        @(posedge clk);
        #1;
        inq.push_back(mk(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1));
        run_queue(1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("le9_idx", out_idx, 32'd0);
        check("le9_sum", out_sum, 32'h0002);
        check("le9_err", out_err, 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Randomized operations with random backpressure and idle gaps
        for (int op = 0; op < 40; op++) begin
            n = $urandom_range(1, MW);
            forced = ($urandom_range(0, 7) == 0);
            if (forced) n = MW;
            for (int k = 0; k < n; k++)
                inq.push_back(mk(rv(), rv(), 1'($urandom), 1'($urandom), (k == n - 1) && !forced));
        end
        run_queue(1'b1);
        drain();

        // Reset in the middle of an operation
        sb_en = 1'b0;
        out_ready = 1'b1;
        send(mk(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0), 1'b0, c);
        send(mk(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0), 1'b0, c);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr_valid", out_valid, 32'd0);
        check("mr_sum",   out_sum,   32'd0);
        check("mr_idx",   out_idx,   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(mk(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1), 1'b0, c);
        in_valid = 1'b0;
        @(negedge clk);
        check("mr2_valid", out_valid, 32'd1);
        check("mr2_sum",   out_sum,   32'h0007);
        check("mr2_idx",   out_idx,   32'd0);
        check("mr2_last",  out_last,  32'd1);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
